serial_add_ctrl: RTL and testbench

Multi-cycle sequencer for digit-serial addition of two WIDTH-bit operands. Each cycle it processes DIGIT bits through a ripple of DIGIT propagate/generate/sum bit cells and keeps the carry in a register between digits. It gives the datapath a wide adder with a small combinational footprint, driven by a start/busy/done handshake.

---
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Digit-serial adder sequencer: adds two WIDTH-bit operands DIGIT bits per cycle,
// carrying between digits through a register, with a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [DIGIT-1:0] w_s;
    logic [DIGIT:0]   w_c;
    logic [WIDTH-1:0] w_ps_next;
    logic             w_accept;
    logic             w_last;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One digit of propagate/generate ripple; c_0 comes from the carry register
    always_comb begin
        w_c    = '0;
        w_s    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            w_s[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
            w_c[i+1] = (r_a[i] & r_b[i]) | ((r_a[i] | r_b[i]) & w_c[i]);
        end
    end

    // Only the upper WIDTH-DIGIT partial-sum bits need storing; the newest digit
    // is still combinational when the result is captured.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_ps_next = w_s;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] r_ps;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ps <= '0;
                end else if (r_state == S_RUN) begin
                    r_ps <= w_ps_next[WIDTH-1:DIGIT];
                end
            end
            assign w_ps_next = {w_s, r_ps};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_c[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                sum  <= w_ps_next;
                cout <= w_c[DIGIT];
                ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: three instances (DIGIT=1,4,16) share stimulus;
// directed table, handshake and reset sequences, then random ops against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;

    logic          busy1, done1, cout1, ovf1;
    logic          busy4, done4, cout4, ovf4;
    logic          busy16, done16, cout16, ovf16;
    logic [W-1:0]  sum1, sum4, sum16;

    int n_err = 0;
    int n_chk = 0;

    serial_add_ctrl #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_add_ctrl #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    serial_add_ctrl #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] t;
        int xs, ys, ss;
        t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        xs = int'($signed(x));
        ys = int'($signed(y));
        ss = xs + ys + int'(c);
        s  = t[W-1:0];
        co = t[W];
        ov = (ss > 32767) || (ss < -32768);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one op on all instances (all must be idle) and check each result and latency
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic [W-1:0] es, input logic eco, input logic eov);
        int lat1, lat4, lat16, bc1, bc4, bc16;
        lat1 = 0; lat4 = 0; lat16 = 0; bc1 = 0; bc4 = 0; bc16 = 0;
        tick();
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tc;
        for (int c = 1; c <= 40; c++) begin
            if (busy1)  bc1++;
            if (busy4)  bc4++;
            if (busy16) bc16++;
            if (done1  && lat1  == 0) lat1  = c;
            if (done4  && lat4  == 0) lat4  = c;
            if (done16 && lat16 == 0) lat16 = c;
            if (lat1 != 0 && lat4 != 0 && lat16 != 0) break;
            tick();
        end
        chk({tag, " d4 sum"},  32'(sum4),  32'(es));
        chk({tag, " d4 cout"}, 32'(cout4), 32'(eco));
        chk({tag, " d4 ovf"},  32'(ovf4),  32'(eov));
        chk({tag, " d4 lat"},  32'(lat4),  32'd5);
        chk({tag, " d4 busy"}, 32'(bc4),   32'd4);
        chk({tag, " d1 sum"},  32'(sum1),  32'(es));
        chk({tag, " d1 cout"}, 32'(cout1), 32'(eco));
        chk({tag, " d1 ovf"},  32'(ovf1),  32'(eov));
        chk({tag, " d1 lat"},  32'(lat1),  32'd17);
        chk({tag, " d16 sum"},  32'(sum16),  32'(es));
        chk({tag, " d16 cout"}, 32'(cout16), 32'(eco));
        chk({tag, " d16 ovf"},  32'(ovf16),  32'(eov));
        chk({tag, " d16 lat"},  32'(lat16),  32'd2);
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rc, eco, eov;
        bit           saw_done;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst done", 32'(done4), 32'd0);
        chk("rst sum",  32'(sum4),  32'd0);
        chk("rst cout", 32'(cout4), 32'd0);
        chk("rst ovf",  32'(ovf4),  32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                   tbl[i].s, tbl[i].co, tbl[i].ov);
        end

        // Back-to-back: start held through RUN with new operands, re-accepted in DONE
        tick();
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        tick();
        a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hs busy c%0d", k + 1), 32'(busy4), 32'd1);
            chk($sformatf("hs nodone c%0d", k + 1), 32'(done4), 32'd0);
            tick();
        end
        chk("hs first done", 32'(done4), 32'd1);
        chk("hs first sum",  32'(sum4),  32'h3333);
        tick();
        start = 1'b0;
        chk("hs rebusy", 32'(busy4), 32'd1);
        chk("hs hold0",  32'(sum4),  32'h3333);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("hs hold%0d", k), 32'(sum4), 32'h3333);
            chk($sformatf("hs gap done%0d", k), 32'(done4), 32'd0);
        end
        tick();
        chk("hs second done", 32'(done4), 32'd1);
        chk("hs second sum",  32'(sum4),  32'h1011);
        chk("hs second cout", 32'(cout4), 32'd0);
        repeat (14) tick();

        // Reset during the second RUN cycle discards the op
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst busy", 32'(busy4), 32'd0);
        chk("mid rst done", 32'(done4), 32'd0);
        chk("mid rst sum",  32'(sum4),  32'd0);
        chk("mid rst cout", 32'(cout4), 32'd0);
        chk("mid rst ovf",  32'(ovf4),  32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done4) saw_done = 1'b1;
            tick();
        end
        chk("mid rst no done", 32'(saw_done), 32'd0);
        run_op("post rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 65535));
            rb = W'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rc, es, eco, eov);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, es, eco, eov);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
